// File: rtl/mod_n_arbiter.sv
// mod_n_arbiter: round-robin arbiter sharing one mod-N reduction unit between two requesters
module mod_n_arbiter #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 4096,
  parameter int RESULT_BLOCKS = BITS_IN_NUM / REGISTER_SIZE
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [1:0]               req_in,
  input  logic [REGISTER_SIZE-1:0] num0_in,
  input  logic [REGISTER_SIZE-1:0] num1_in,
  input  logic [1:0]               valid_in,
  output logic [1:0]               grant_out,
  output logic [REGISTER_SIZE-1:0] mod_num_out,
  output logic                     mod_valid_out,
  input  logic [REGISTER_SIZE-1:0] mod_data_in,
  input  logic                     mod_valid_in,
  output logic [REGISTER_SIZE-1:0] res_data_out,
  output logic [1:0]               res_valid_out,
  output logic                     res_last_out,
  output logic                     busy_out,
  output logic                     err_out
);
  localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int IW = NUM_BLOCKS > 1 ? $clog2(NUM_BLOCKS) : 1;
  localparam int RW = RESULT_BLOCKS > 1 ? $clog2(RESULT_BLOCKS) : 1;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t          r_state, w_next;
  logic            r_owner, r_last_served;
  logic [IW-1:0]   r_icnt;
  logic [RW-1:0]   r_rcnt;
  logic            w_pick, w_start, w_in_fire, w_in_done, w_res_fire, w_res_done;
  logic [1:0]      w_owner_oh;
  assign w_pick     = &req_in ? ~r_last_served : req_in[1];
  assign w_start    = r_state == IDLE && |req_in;
  assign w_in_fire  = r_state == STREAM && valid_in[r_owner];
  assign w_in_done  = w_in_fire && r_icnt == IW'(NUM_BLOCKS - 1);
  assign w_res_fire = r_state == DRAIN && mod_valid_in;
  assign w_res_done = w_res_fire && r_rcnt == RW'(RESULT_BLOCKS - 1);
  assign w_owner_oh = r_owner ? 2'b10 : 2'b01;
  // state register
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state: grant on request, drain after the last operand block, idle after the last result
  always_comb begin
    w_next = w_start ? STREAM : w_in_done ? DRAIN : w_res_done ? IDLE : r_state;
  end
  // outputs decoded from state; operand stream is a combinational mux of the owner's inputs
  always_comb begin
    grant_out     = r_state == STREAM ? w_owner_oh : 2'b00;
    mod_valid_out = w_in_fire;
    mod_num_out   = r_state == STREAM ? (r_owner ? num1_in : num0_in) : '0;
    busy_out      = r_state != IDLE;
  end
  // owner, round-robin history and block counters; counters clear at their terminal count
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_owner       <= 1'b0;
      r_last_served <= 1'b1;
      r_icnt        <= '0;
      r_rcnt        <= '0;
    end else begin
      if (w_start) r_owner <= w_pick;
      if (w_res_done) r_last_served <= r_owner;
      r_icnt <= w_in_done ? '0 : w_in_fire ? r_icnt + 1'b1 : r_icnt;
      r_rcnt <= w_res_done ? '0 : w_res_fire ? r_rcnt + 1'b1 : r_rcnt;
    end
  end
  // registered result stream steered to the owner; stray results are dropped and flagged
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      res_data_out  <= '0;
      res_valid_out <= 2'b00;
      res_last_out  <= 1'b0;
      err_out       <= 1'b0;
    end else begin
      res_valid_out <= w_res_fire ? w_owner_oh : 2'b00;
      res_last_out  <= w_res_done;
      if (w_res_fire) res_data_out <= mod_data_in;
      err_out <= err_out | (mod_valid_in && r_state != DRAIN);
    end
  end
endmodule

// File: tb/tb_mod_n_arbiter.sv
// tb_mod_n_arbiter: directed and randomized operations checked against a transaction-level model
module tb_mod_n_arbiter;
  localparam int RS = 32, BN = 128, RB = 4, NB = BN / RS;
  logic          clk_in = 0, rst_in;
  logic [1:0]    req_in, valid_in, grant_out, res_valid_out;
  logic [RS-1:0] num0_in, num1_in, mod_num_out, mod_data_in, res_data_out;
  logic          mod_valid_out, mod_valid_in, res_last_out, busy_out, err_out;
  int            passes = 0, fails = 0, total = 0;
  bit            last_served = 1, exp_err = 0, o;
  mod_n_arbiter #(.REGISTER_SIZE(RS), .BITS_IN_NUM(BN), .RESULT_BLOCKS(RB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .num0_in(num0_in), .num1_in(num1_in),
    .valid_in(valid_in), .grant_out(grant_out), .mod_num_out(mod_num_out),
    .mod_valid_out(mod_valid_out), .mod_data_in(mod_data_in), .mod_valid_in(mod_valid_in),
    .res_data_out(res_data_out), .res_valid_out(res_valid_out), .res_last_out(res_last_out),
    .busy_out(busy_out), .err_out(err_out));
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  function automatic logic [1:0] oh(input bit b);
    return b ? 2'b10 : 2'b01;
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, grant_out, 0);
    chk({tag, "_mvalid"}, mod_valid_out, 0);
    chk({tag, "_mnum"}, mod_num_out, 0);
    chk({tag, "_rvalid"}, res_valid_out, 0);
    chk({tag, "_rlast"}, res_last_out, 0);
    chk({tag, "_rdata"}, res_data_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_err"}, err_out, 0);
  endtask
  task automatic do_reset;
    rst_in = 1;
    req_in = 0;
    valid_in = 0;
    mod_valid_in = 0;
    tick;
    #1;
    chk_zero("reset");
    rst_in = 0;
    last_served = 1;
    exp_err = 0;
    tick;
  endtask
  // one full operation: rs is ORed into req_in in IDLE, rd during DRAIN; mode 0 = gapless,
  // 1 = random gaps, 2 = owner valid pattern 1,0,0,1,1,1; abort stops after that many results
  task automatic serve(input logic [1:0] rs, input logic [1:0] rd, input int mode, input int abort, output bit own);
    logic [5:0]  pat;
    int          cnt, k, pulses, r;
    bit          v, mv, pv, pl;
    logic [31:0] ob, pd;
    pat = 6'b111001;
    req_in = req_in | rs;
    own = (req_in == 2'b11) ? !last_served : req_in[1];
    #1;
    chk("idle_grant", grant_out, 0);
    chk("idle_busy", busy_out, 0);
    tick;
    cnt = 0;
    k = 0;
    pulses = 0;
    while (cnt < NB && k < 64) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : pat[k % 6];
      ob = mode == 0 ? 32'h11 * (cnt + 1) : $urandom;
      if (own) begin
        num1_in = ob;
        num0_in = $urandom;
      end else begin
        num0_in = ob;
        num1_in = $urandom;
      end
      valid_in[own] = v;
      valid_in[!own] = 1'($urandom_range(0, 1));
      #1;
      chk("stream_grant", grant_out, oh(own));
      chk("stream_busy", busy_out, 1);
      chk("stream_valid", mod_valid_out, v);
      if (v) chk("stream_num", mod_num_out, ob);
      pulses += mod_valid_out;
      cnt += v;
      k++;
      req_in[own] = 0;
      tick;
    end
    chk("stream_pulses", pulses, NB);
    if (mode == 2) chk("stall_cycles", k, 6);
    valid_in = 2'b11;
    req_in = req_in | rd;
    pv = 0;
    pl = 0;
    pd = 0;
    r = 0;
    k = 0;
    while (r < RB && k < 128) begin
      if (r == abort) return;
      mv = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      mod_valid_in = mv;
      mod_data_in = $urandom;
      #1;
      chk("drain_grant", grant_out, 0);
      chk("drain_mvalid", mod_valid_out, 0);
      chk("drain_busy", busy_out, 1);
      chk("res_valid", res_valid_out, pv ? oh(own) : 2'b00);
      if (pv) chk("res_data", res_data_out, pd);
      chk("res_last", res_last_out, pl);
      pv = mv;
      pd = mod_data_in;
      r += mv;
      pl = mv && r == RB;
      k++;
      tick;
    end
    chk("drain_done", r, RB);
    mod_valid_in = 0;
    valid_in = 0;
    #1;
    chk("last_valid", res_valid_out, oh(own));
    chk("last_data", res_data_out, pd);
    chk("last_flag", res_last_out, 1);
    chk("last_idle", busy_out, 0);
    chk("last_grant", grant_out, 0);
    chk("err_state", err_out, exp_err);
    last_served = own;
  endtask
  initial begin
    req_in = 0;
    valid_in = 0;
    num0_in = 0;
    num1_in = 0;
    mod_valid_in = 0;
    mod_data_in = 0;
    rst_in = 1;
    tick;
    do_reset;
    serve(2'b01, 2'b00, 0, 99, o);
    tick;
    do_reset;
    serve(2'b11, 2'b01, 0, 99, o);
    serve(2'b00, 2'b00, 0, 99, o);
    serve(2'b00, 2'b00, 0, 99, o);
    serve(2'b10, 2'b00, 2, 99, o);
    mod_valid_in = 1;
    mod_data_in = 32'hDEAD_BEEF;
    tick;
    mod_valid_in = 0;
    #1;
    chk("err_drop_valid", res_valid_out, 0);
    chk("err_set", err_out, 1);
    exp_err = 1;
    serve(2'b01, 2'b00, 1, 99, o);
    tick;
    do_reset;
    serve(2'b01, 2'b00, 0, 2, o);
    do_reset;
    serve(2'b10, 2'b00, 0, 99, o);
    for (int i = 0; i < 8; i++) begin
      if (req_in == 0 && $urandom_range(0, 1) == 1) tick;
      serve(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 1, 99, o);
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/mod_n_arbiter.md
MOD_N_ARBITER -- requirements
Module: mod_n_arbiter

Interface
REQ-001 SHALL have parameter REGISTER_SIZE, default 32, block width in bits.
REQ-002 SHALL have parameter BITS_IN_NUM, default 4096, operand width; NUM_BLOCKS = BITS_IN_NUM/REGISTER_SIZE.
REQ-003 SHALL have parameter RESULT_BLOCKS, default BITS_IN_NUM/REGISTER_SIZE, result blocks returned by the reduction unit per operation.
REQ-004 SHALL have port clk_in, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port req_in, input, 2, per-requester operation request; held high until the matching grant_out bit rises.
REQ-007 SHALL have ports num0_in and num1_in, input, REGISTER_SIZE each, requester operand blocks, LSB block first.
REQ-008 SHALL have port valid_in, input, 2, per-requester block valid.
REQ-009 SHALL have port grant_out, output, 2, one-hot; high while that requester owns the input stream.
REQ-010 SHALL have ports mod_num_out (output, REGISTER_SIZE) and mod_valid_out (output, 1), the block stream into the shared mod-N reduction unit.
REQ-011 SHALL have ports mod_data_in (input, REGISTER_SIZE) and mod_valid_in (input, 1), the result stream from the reduction unit.
REQ-012 SHALL have ports res_data_out (output, REGISTER_SIZE), res_valid_out (output, 2, one-hot owner steering) and res_last_out (output, 1), the returned result stream.
REQ-013 SHALL have ports busy_out (output, 1; high in any state except IDLE) and err_out (output, 1; sticky protocol error).

Function
REQ-014 SHALL implement the states IDLE, STREAM and DRAIN, plus a 1-bit owner register, a last_served register, an input block counter and a result block counter.
REQ-015 In IDLE with any req_in bit high, the FSM SHALL move to STREAM next cycle and set the owner; grant_out rises in that same cycle.
REQ-016 Owner selection SHALL be round-robin: a single request wins; with both requests high, the requester other than last_served wins; last_served resets to 1 so requester 0 wins first.
REQ-017 In STREAM, mod_num_out SHALL combinationally equal the owner's num block and mod_valid_out SHALL equal valid_in[owner]; the non-owner's valid_in SHALL be ignored.
REQ-018 The input counter SHALL advance only on owner valid; gaps stall without loss.
REQ-019 On the NUM_BLOCKS-th owner valid, the FSM SHALL move to DRAIN, clear grant_out next cycle and reset the input counter.
REQ-020 In DRAIN, each mod_valid_in SHALL produce, one cycle later, res_data_out = mod_data_in and res_valid_out = one-hot(owner).
REQ-021 res_last_out SHALL be high with the RESULT_BLOCKS-th result block; the same edge SHALL set last_served to the owner and return the FSM to IDLE.
REQ-022 At most one operation SHALL be in flight, because the reduction unit accepts no new operand until its result is fully emitted; no request is granted during DRAIN.
REQ-023 Requests arriving in DRAIN SHALL be held pending and arbitrated in IDLE; the earliest new grant is 1 cycle after res_last_out.
REQ-024 A mod_valid_in outside DRAIN SHALL be dropped, with no res_valid_out, and SHALL set err_out.
REQ-025 mod_valid_out SHALL never be high outside STREAM.
REQ-026 Both counters SHALL be $clog2 width and SHALL never wrap past their terminal count.

Reset
REQ-027 On rst_in, the FSM SHALL enter IDLE, clear both counters and set last_served to 1.
REQ-028 On rst_in, grant_out, mod_valid_out, res_valid_out, res_last_out, busy_out, err_out and res_data_out SHALL all be 0.
REQ-029 Reset asserted mid-STREAM or mid-DRAIN SHALL abort the operation with no further output; the reduction unit shares rst_in.

Verification
REQ-030 SHALL cover single request: REGISTER_SIZE=32, BITS_IN_NUM=128, RESULT_BLOCKS=4; req_in=01, 4 blocks 0x11..0x44 -> mod_num_out carries 0x11..0x44 with grant_out=01; a 4-block result -> res_valid_out=01 on each block, res_last_out on the 4th.
REQ-031 SHALL cover simultaneous requests after reset: req_in=11 -> requester 0 served first, then requester 1; results steered 01 then 10.
REQ-032 SHALL cover fairness: requester 0 re-requests during its own DRAIN while requester 1 waits -> requester 1 granted next.
REQ-033 SHALL cover stall: owner valid toggles 1,0,0,1,1,1 -> exactly 4 mod_valid_out pulses, then DRAIN.
REQ-034 SHALL cover error: mod_valid_in pulsed in IDLE -> no res_valid_out, err_out=1 until rst_in.
REQ-035 SHALL cover reset mid-DRAIN after 2 result blocks -> all outputs 0 next cycle, and a new request is granted normally.
